// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch target buffer: control-flow type codes,
// field widths and the index-width helper.
// Latency: n/a (constants only). Backpressure: n/a.
package bp_pkg;

  // Control-flow type encoding carried on upd_type and stored per entry.
  localparam logic [1:0] BR_COND = 2'd0;
  localparam logic [1:0] BR_JAL  = 2'd1;
  localparam logic [1:0] BR_JALR = 2'd2;
  localparam logic [1:0] BR_NONE = 2'd3;

  // Width of the stored type field.
  localparam int TYPE_W = 2;

  // Number of index bits needed to address a table of the given depth.
  function automatic int calc_idx_w(input int entries);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < entries) w = w + 1;
    end
    return w;
  endfunction

  // Width of one table entry payload: valid + tag + target + type.
  function automatic int entry_w(input int tag_w, input int addr_w);
    return 1 + tag_w + addr_w + TYPE_W;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter for one table entry's branch direction.
// Latency: 1 cycle (new value visible after the rising edge). Backpressure: none.
// Ports: clk/rst_n, inc/dec step the count without wrapping, load forces
// load_val (load has priority over inc, inc over dec); value is the state.
module sat_counter #(
  parameter int               CNT_W   = 2,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;
  localparam logic [CNT_W-1:0] MIN_VAL = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (inc && (value != MAX_VAL)) begin
      value <= value + CNT_W'(1);
    end else if (dec && (value != MIN_VAL)) begin
      value <= value - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters; IF gets
// a predicted next PC, EX trains the table with resolved control flow.
// Latency: lookup is combinational (0 cycles), updates land on the next edge.
// Backpressure: none; every accepted update is absorbed in the cycle it arrives.
// Ports: cpu_clk/cpu_rst (async active-low); pred_pc -> pred_taken/pred_npc;
// upd_* training interface from EX; bp_flush invalidates all entries;
// stat_branches/stat_mispred counters exist only when BP_STATS_EN is defined,
// otherwise they read as 0 (port list unchanged).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_npc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [1:0]        upd_type,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              bp_flush,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred
);

  localparam int IDX_W = calc_idx_w(ENTRIES);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Weakly taken is the MSB alone; weakly not-taken is one below it.
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

  // Table state. Only valid bits and counters are reset; tag/target/type are
  // qualified by valid so their power-up contents never matter.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [TYPE_W-1:0]  type_q   [ENTRIES];
  logic [CNT_W-1:0]   cnt      [ENTRIES];

  // ---------------- Lookup ----------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = pred_pc[IDX_W+1:2];
  assign lk_tag = pred_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  // Jumps always redirect on a hit; conditionals follow the counter MSB.
  assign pred_taken = lk_hit && ((type_q[lk_idx] != BR_COND) || cnt[lk_idx][CNT_W-1]);
  assign pred_npc   = pred_taken ? target_q[lk_idx] : pred_pc + ADDR_W'(4);

  // ---------------- Update ----------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_jump;
  logic             upd_accept;
  logic             u_write;
  logic             cnt_load;
  logic             cnt_inc;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;

  assign u_idx  = upd_pc[IDX_W+1:2];
  assign u_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_jump = (upd_type == BR_JAL) || (upd_type == BR_JALR);

  // A flush in the same cycle swallows the update entirely.
  assign upd_accept = upd_valid && (upd_type != BR_NONE) && !bp_flush;

  // Taken outcomes rewrite the entry on a hit and allocate it on a miss;
  // rewriting the tag on a hit is harmless since it already matches.
  assign u_write = upd_accept && upd_taken;

  assign cnt_load     = (upd_accept && u_hit && u_jump) || (u_write && !u_hit);
  assign cnt_load_val = u_jump ? CNT_MAX : CNT_WT;
  assign cnt_inc      = upd_accept && u_hit && !u_jump && upd_taken;
  assign cnt_dec      = upd_accept && u_hit && !u_jump && !upd_taken;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      valid_q <= '0;
    end else if (bp_flush) begin
      valid_q <= '0;
    end else if (u_write) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (u_write) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
      type_q[u_idx]   <= upd_type;
    end
  end

  // Counters survive a flush; only reset returns them to weakly not-taken.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
    logic sel;
    assign sel = (u_idx == IDX_W'(i));

    sat_counter #(
      .CNT_W   (CNT_W),
      .RST_VAL (CNT_WNT)
    ) u_cnt (
      .clk      (cpu_clk),
      .rst_n    (cpu_rst),
      .inc      (cnt_inc && sel),
      .dec      (cnt_dec && sel),
      .load     (cnt_load && sel),
      .load_val (cnt_load_val),
      .value    (cnt[i])
    );
  end

  // ---------------- Statistics ----------------
`ifdef BP_STATS_EN
  logic [31:0] branches_q;
  logic [31:0] mispred_q;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else if (upd_accept) begin
      branches_q <= branches_q + 32'd1;
      if (upd_mispredict) begin
        mispred_q <= mispred_q + 32'd1;
      end
    end
  end

  assign stat_branches = branches_q;
  assign stat_mispred  = mispred_q;

  // PC bits outside the index/tag window carry no information for the table.
  logic unused_upd_bits;
  assign unused_upd_bits = ^{upd_pc};
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;

  // Mispredict flag only feeds the statistics; outer PC bits are not stored.
  logic unused_upd_bits;
  assign unused_upd_bits = ^{upd_pc, upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16, TAG_W=8, CNT_W=2).
// Stimulus drives one cycle at a time and queues the predicted response of a
// table model; a separate monitor pops and compares every presented lookup.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 2;
  localparam int ADDR_W  = 32;
  localparam int CNT_TOP = (1 << CNT_W) - 1;
  localparam int CNT_MID = 1 << (CNT_W - 1);

  logic              cpu_clk = 1'b0;
  logic              cpu_rst = 1'b0;
  logic [ADDR_W-1:0] pred_pc = '0;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_npc;
  logic              upd_valid = 1'b0;
  logic [ADDR_W-1:0] upd_pc = '0;
  logic [1:0]        upd_type = '0;
  logic              upd_taken = 1'b0;
  logic [ADDR_W-1:0] upd_target = '0;
  logic              upd_mispredict = 1'b0;
  logic              bp_flush = 1'b0;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispred;

  always #5 cpu_clk = ~cpu_clk;

  branch_predictor #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_npc       (pred_npc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_type       (upd_type),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .bp_flush       (bp_flush),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  typedef struct {
    logic        tk;
    logic [31:0] npc;
    logic [31:0] sb;
    logic [31:0] sm;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  event sample_ev;

  // ---------------- Reference model ----------------
  bit          mv   [ENTRIES];
  int          mtag [ENTRIES];
  logic [31:0] mtgt [ENTRIES];
  int          mtyp [ENTRIES];
  int          mcnt [ENTRIES];
  logic [31:0] m_sb;
  logic [31:0] m_sm;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      mv[i]   = 1'b0;
      mcnt[i] = CNT_MID - 1;
    end
    m_sb = 0;
    m_sm = 0;
  endfunction

  function automatic int pc_idx(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int pc_tag(logic [31:0] pc);
    return int'((pc >> (2 + $clog2(ENTRIES))) % (1 << TAG_W));
  endfunction

  function automatic exp_t model_predict(logic [31:0] pc);
    exp_t e;
    int   i;
    bit   hit;
    i   = pc_idx(pc);
    hit = mv[i] && (mtag[i] == pc_tag(pc));
    e.tk  = hit && ((mtyp[i] != 0) || (mcnt[i] >= CNT_MID));
    e.npc = e.tk ? mtgt[i] : pc + 32'd4;
`ifdef BP_STATS_EN
    e.sb = m_sb;
    e.sm = m_sm;
`else
    e.sb = 0;
    e.sm = 0;
`endif
    e.id = cyc;
    return e;
  endfunction

  function automatic void model_update(bit uv, logic [31:0] upc, int ut, bit tk,
                                       logic [31:0] tgt, bit mis, bit fl);
    int i;
    bit hit;
    bit jump;
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) mv[k] = 1'b0;
      return;
    end
    if (!uv || ut == 3) return;
    m_sb = m_sb + 1;
    if (mis) m_sm = m_sm + 1;
    i    = pc_idx(upc);
    hit  = mv[i] && (mtag[i] == pc_tag(upc));
    jump = (ut == 1) || (ut == 2);
    if (hit) begin
      if (jump)    mcnt[i] = CNT_TOP;
      else if (tk) mcnt[i] = (mcnt[i] < CNT_TOP) ? mcnt[i] + 1 : CNT_TOP;
      else         mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
      if (tk) begin
        mtgt[i] = tgt;
        mtyp[i] = ut;
      end
    end else if (tk) begin
      mv[i]   = 1'b1;
      mtag[i] = pc_tag(upc);
      mtgt[i] = tgt;
      mtyp[i] = ut;
      mcnt[i] = jump ? CNT_TOP : CNT_MID;
    end
  endfunction

  // ---------------- Scoreboard ----------------
  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s sample=%0d got=0x%08h want=0x%08h", name, id, act, exp);
    end
  endtask

  task automatic push_and_sample();
    q.push_back(model_predict(pred_pc));
    -> sample_ev;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow sample=%0d", cyc);
      end else begin
        e = q.pop_front();
        check("pred_taken",    e.id, {31'd0, pred_taken}, {31'd0, e.tk});
        check("pred_npc",      e.id, pred_npc,            e.npc);
        check("stat_branches", e.id, stat_branches,       e.sb);
        check("stat_mispred",  e.id, stat_mispred,        e.sm);
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic cycle(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                       input int ut, input bit tk, input logic [31:0] tgt,
                       input bit mis, input bit fl);
    @(negedge cpu_clk);
    pred_pc        = pc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_type       = 2'(ut);
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mis;
    bp_flush       = fl;
    #2;
    push_and_sample();
    model_update(uv, upc, ut, tk, tgt, mis, fl);
    cyc++;
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(pc, 1'b0, 32'd0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = ($urandom() << 14) | ($urandom_range(0, 2) << 6)
      | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    return p;
  endfunction

  task automatic mid_reset();
    @(posedge cpu_clk);
    #2;
    cpu_rst   = 1'b0;
    upd_valid = 1'b0;
    bp_flush  = 1'b0;
    #1;
    model_reset();
    push_and_sample();
    @(negedge cpu_clk);
    #2;
    cpu_rst = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout at sample=%0d", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    logic [31:0] pc, upc, tgt;
    int          ut;
    bit          tk;
    model_reset();
    pred_pc = 32'h100;
    #3;
    push_and_sample();            // state held in reset
    #9;
    cpu_rst = 1'b1;

    // Reset state seen after release.
    look(32'h100);
    // Conditional allocate, then walk the counter down without wrapping.
    cycle(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 0);
    cycle(32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 0);   // sees taken to 0x80
    cycle(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0);   // counter 01: not taken
    cycle(32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 0);
    cycle(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 0);  // 00 -> 01 only
    look(32'h100);
    // jal then a conflicting tag on the same index.
    cycle(32'h200, 1, 32'h200, 1, 1, 32'h400, 0, 0);
    cycle(32'h200, 1, 32'h1200, 0, 1, 32'h10, 0, 0);
    look(32'h1200);
    look(32'h200);
    // Flush wins over a simultaneous update.
    cycle(32'h300, 1, 32'h300, 0, 1, 32'h500, 0, 1);
    look(32'h300);
    // Lookup and update in the same cycle: no bypass.
    cycle(32'h100, 1, 32'h100, 0, 1, 32'h40, 0, 0);
    look(32'h100);
    // pred_pc + 4 wraps.
    look(32'hFFFF_FFFC);
    // Ignored type 3 and low PC bits.
    cycle(32'h104, 1, 32'h107, 3, 1, 32'h999, 1, 0);
    cycle(32'h104, 1, 32'h107, 2, 1, 32'h888, 1, 0);
    look(32'h105);

    // Randomized traffic with a mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) mid_reset();
      pc  = rand_pc();
      upc = ($urandom_range(0, 3) == 0) ? pc : rand_pc();
      ut  = $urandom_range(0, 3);
      tk  = (ut == 1 || ut == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      tgt = $urandom() & 32'hFFFF_FFFC;
      cycle(pc, 1'($urandom_range(0, 3) != 0), upc, ut, tk, tgt,
            1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
    end

    @(negedge cpu_clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
